// File: rtl/speech256_pkg.sv
// Shared constants and FSM state type for the synthesis-filter host sequencer.
package speech256_pkg;

  localparam int COEF_W   = 10;
  localparam int SIG_W    = 16;
  localparam int NCOEF    = 12;
  localparam int SECTIONS = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    START   = 3'd2,
    WAIT_LO = 3'd3,
    WAIT_HI = 3'd4,
    OUT     = 3'd5
  } seq_state_t;

endpackage

// File: rtl/coef_frame_buf.sv
// One-frame coefficient buffer: serial write side from the decoder,
// random read port used by the sequencer while loading the filter.
module coef_frame_buf #(
  parameter int NCOEF  = speech256_pkg::NCOEF,
  parameter int COEF_W = speech256_pkg::COEF_W,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [COEF_W-1:0] i_wr_data,
  input  logic              i_clr_pending,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [COEF_W-1:0] o_rd_data,
  output logic              o_pending,
  output logic              o_pending_nxt
);
  import speech256_pkg::*;

  localparam logic [IDX_W-1:0] WI_LAST = IDX_W'(NCOEF - 1);

  logic [COEF_W-1:0] r_buf [NCOEF];
  logic [IDX_W-1:0]  r_wi;
  logic              r_pending;
  logic              w_last_beat;
  logic              w_pending_nxt;

  // Next value of the frame-complete flag; clear (after LOAD) and set
  // (last beat) never coincide because frm_ready is low during LOAD.
  always_comb begin
    w_last_beat   = 1'b0;
    w_pending_nxt = r_pending;
    if (i_wr_en && (r_wi == WI_LAST)) begin
      w_last_beat = 1'b1;
    end else begin
      w_last_beat = 1'b0;
    end
    if (i_clr_pending) begin
      w_pending_nxt = 1'b0;
    end else if (w_last_beat) begin
      w_pending_nxt = 1'b1;
    end else begin
      w_pending_nxt = r_pending;
    end
  end

  // Write index and pending flag; the index wraps once a frame is complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wi      <= '0;
      r_pending <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_last_beat) begin
        r_wi <= '0;
      end else if (i_wr_en) begin
        r_wi <= r_wi + IDX_W'(1);
      end else begin
        r_wi <= r_wi;
      end
    end
  end

  // Coefficient storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_buf[r_wi] <= i_wr_data;
    end
  end

  assign o_rd_data     = r_buf[i_rd_idx];
  assign o_pending     = r_pending;
  assign o_pending_nxt = w_pending_nxt;

endmodule

// File: rtl/filter_sequencer.sv
// Host-side sequencer for the 12th-order all-pole synthesis filter:
// buffers a coefficient frame, loads it at a sample boundary, runs the
// filter sections and hands the result to the PWM/DAC stage.
// All outputs are registered; next values are computed in one comb block.
module filter_sequencer #(
  parameter int NCOEF    = speech256_pkg::NCOEF,
  parameter int SECTIONS = speech256_pkg::SECTIONS,
  parameter int COEF_W   = speech256_pkg::COEF_W,
  parameter int SIG_W    = speech256_pkg::SIG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COEF_W-1:0] frm_coef,
  input  logic              frm_valid,
  output logic              frm_ready,
  input  logic              sample_stb,
  input  logic [SIG_W-1:0]  src_in,
  output logic [COEF_W-1:0] flt_coef,
  output logic              flt_coef_load,
  output logic [SIG_W-1:0]  flt_sig,
  output logic              flt_start,
  input  logic              flt_done,
  input  logic [SIG_W-1:0]  flt_result,
  output logic [SIG_W-1:0]  pcm_out,
  output logic              pcm_valid,
  output logic              overrun
);
  import speech256_pkg::*;

  localparam int LC_W  = (NCOEF > 1) ? $clog2(NCOEF) : 1;
  localparam int SEC_W = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
  localparam logic [LC_W-1:0]  LC_LAST  = LC_W'(NCOEF - 1);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SECTIONS - 1);

  seq_state_t        r_state, w_state_nxt;
  logic [LC_W-1:0]   r_lc, w_lc_nxt;
  logic [SEC_W-1:0]  r_sec, w_sec_nxt;

  logic              r_frm_ready, w_frm_ready_nxt;
  logic [COEF_W-1:0] r_flt_coef, w_coef_nxt;
  logic              r_flt_coef_load, w_coef_load_nxt;
  logic [SIG_W-1:0]  r_flt_sig, w_sig_nxt;
  logic              r_flt_start, w_start_nxt;
  logic [SIG_W-1:0]  r_pcm_out, w_pcm_nxt;
  logic              r_pcm_valid, w_pcm_valid_nxt;
  logic              r_overrun, w_overrun_nxt;

  logic              w_accept;
  logic              w_clr_pending;
  logic [LC_W-1:0]   w_rd_idx;
  logic [COEF_W-1:0] w_rd_data;
  logic              w_pending;
  logic              w_pending_nxt;

  assign w_accept = frm_valid & r_frm_ready;

  coef_frame_buf #(
    .NCOEF  (NCOEF),
    .COEF_W (COEF_W),
    .IDX_W  (LC_W)
  ) u_buf (
    .clk           (clk),
    .rst           (rst),
    .i_wr_en       (w_accept),
    .i_wr_data     (frm_coef),
    .i_clr_pending (w_clr_pending),
    .i_rd_idx      (w_rd_idx),
    .o_rd_data     (w_rd_data),
    .o_pending     (w_pending),
    .o_pending_nxt (w_pending_nxt)
  );

  // Next state and next registered outputs. The pending flag is read
  // before its update, so a frame completing alongside a strobe waits
  // for the following strobe.
  always_comb begin
    w_state_nxt     = r_state;
    w_lc_nxt        = r_lc;
    w_sec_nxt       = r_sec;
    w_rd_idx        = '0;
    w_clr_pending   = 1'b0;
    w_coef_nxt      = r_flt_coef;
    w_coef_load_nxt = 1'b0;
    w_sig_nxt       = r_flt_sig;
    w_start_nxt     = 1'b0;
    w_pcm_nxt       = r_pcm_out;
    w_pcm_valid_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (sample_stb) begin
          w_sig_nxt = src_in;
          w_sec_nxt = '0;
          if (w_pending) begin
            w_state_nxt     = LOAD;
            w_lc_nxt        = '0;
            w_rd_idx        = '0;
            w_coef_load_nxt = 1'b1;
            w_coef_nxt      = w_rd_data;
          end else begin
            w_state_nxt = START;
            w_start_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOAD: begin
        if (r_lc == LC_LAST) begin
          w_clr_pending = 1'b1;
          w_state_nxt   = START;
          w_start_nxt   = 1'b1;
        end else begin
          w_lc_nxt        = r_lc + LC_W'(1);
          w_rd_idx        = r_lc + LC_W'(1);
          w_coef_load_nxt = 1'b1;
          w_coef_nxt      = w_rd_data;
        end
      end
      START: begin
        w_state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        // done is still high the cycle after start; wait for it to drop
        if (!flt_done) begin
          w_state_nxt = WAIT_HI;
        end else begin
          w_state_nxt = WAIT_LO;
        end
      end
      WAIT_HI: begin
        if (flt_done) begin
          if (r_sec == SEC_LAST) begin
            w_state_nxt     = OUT;
            w_pcm_nxt       = flt_result;
            w_pcm_valid_nxt = 1'b1;
          end else begin
            w_sec_nxt   = r_sec + SEC_W'(1);
            w_state_nxt = START;
            w_start_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = WAIT_HI;
        end
      end
      OUT: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_overrun_nxt   = sample_stb && (r_state != IDLE);
    w_frm_ready_nxt = !w_pending_nxt && (w_state_nxt != LOAD);
  end

  // State, counters and all output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_lc            <= '0;
      r_sec           <= '0;
      r_frm_ready     <= 1'b0;
      r_flt_coef      <= '0;
      r_flt_coef_load <= 1'b0;
      r_flt_sig       <= '0;
      r_flt_start     <= 1'b0;
      r_pcm_out       <= '0;
      r_pcm_valid     <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_lc            <= w_lc_nxt;
      r_sec           <= w_sec_nxt;
      r_frm_ready     <= w_frm_ready_nxt;
      r_flt_coef      <= w_coef_nxt;
      r_flt_coef_load <= w_coef_load_nxt;
      r_flt_sig       <= w_sig_nxt;
      r_flt_start     <= w_start_nxt;
      r_pcm_out       <= w_pcm_nxt;
      r_pcm_valid     <= w_pcm_valid_nxt;
      r_overrun       <= w_overrun_nxt;
    end
  end

  assign frm_ready     = r_frm_ready;
  assign flt_coef      = r_flt_coef;
  assign flt_coef_load = r_flt_coef_load;
  assign flt_sig       = r_flt_sig;
  assign flt_start     = r_flt_start;
  assign pcm_out       = r_pcm_out;
  assign pcm_valid     = r_pcm_valid;
  assign overrun       = r_overrun;

endmodule

// File: doc/filter_sequencer.md
# filter_sequencer

Host-side driver for the 12th-order all-pole synthesis filter. It buffers one 12-coefficient frame from the parameter decoder and loads it serially into the filter at a sample boundary. On each sample strobe it drives the excitation sample into the filter and issues one `start` per filter section. After the last section it captures the filter output and presents it to the PWM/DAC stage as a one-cycle-valid PCM word.

## Interface
Parameters:
- `NCOEF`, default 12: coefficients per frame; must equal the filter's coefficient register depth.
- `SECTIONS`, default 6: `start`/`done` handshakes per output sample; the filter consumes 2 coefficients per section.
- `COEF_W`, default 10: coefficient width, sign-magnitude, passed through unchanged.
- `SIG_W`, default 16: signal width, two's complement.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous active-high reset.
- `frm_coef`, in, COEF_W: coefficient beat from the decoder; beat 0 first.
- `frm_valid`, in, 1: a beat is present.
- `frm_ready`, out, 1: a beat is accepted when `frm_valid & frm_ready`.
- `sample_stb`, in, 1: one-cycle sample-rate tick.
- `src_in`, in, SIG_W: excitation sample; valid with `sample_stb`.
- `flt_coef`, out, COEF_W: drives the filter's `coef_in`.
- `flt_coef_load`, out, 1: drives the filter's `coef_load`.
- `flt_sig`, out, SIG_W: drives the filter's `sig_in`.
- `flt_start`, out, 1: drives the filter's `start`.
- `flt_done`, in, 1: the filter's `done`.
- `flt_result`, in, SIG_W: the filter's `sig_out`.
- `pcm_out`, out, SIG_W: last captured output sample.
- `pcm_valid`, out, 1: one-cycle pulse when `pcm_out` updates.
- `overrun`, out, 1: one-cycle pulse when a `sample_stb` is dropped.

## Operation
- **Frame buffer:** NCOEF entries, a write index `wi`, and a `pending` flag.
  - `frm_ready = !pending && state != LOAD`.
  - An accepted beat is written to entry `wi`, and `wi` increments.
  - Accepting beat NCOEF-1 sets `pending` and wraps `wi` to 0.
- **States:** IDLE, LOAD, START, WAIT_LO, WAIT_HI, OUT.
- **IDLE**, on `sample_stb`:
  - Latch `src_in` into the `flt_sig` register.
  - Clear the section counter.
  - Go to LOAD if `pending`, otherwise to START.
- **LOAD:** lasts NCOEF cycles.
  - `flt_coef_load = 1` and `flt_coef = buf[lc]`, for `lc` = 0..NCOEF-1 in consecutive cycles.
  - After `lc = NCOEF-1`: clear `pending`, go to START.
- **START:** `flt_start = 1` for exactly one cycle, then WAIT_LO.
- **WAIT_LO:** wait for `flt_done == 0`. The filter's `done` stays high for 1 cycle after `start`, so it is never sampled as completion there.
- **WAIT_HI:** wait for `flt_done == 1`.
  - If the section counter equals SECTIONS-1, go to OUT.
  - Otherwise increment the counter and go to START.
- **OUT:** register `pcm_out <= flt_result`, pulse `pcm_valid`, go to IDLE.
- **Hold rules:**
  - `flt_sig` holds its value outside IDLE sample capture.
  - `flt_coef` holds its last value outside LOAD.
  - `flt_coef_load` and `flt_start` are 0 outside LOAD and START respectively.
- **Coefficient rotation:** after SECTIONS×2 = NCOEF rotations the filter's coefficient register returns to its load order. No reload is needed for frames that are reused.
- **No arithmetic:** the block performs none; all data passes bit-exact.

## Timing
- **Reset values:** all outputs 0, state IDLE, `wi = 0`, `pending = 0`, buffer contents don't-care. A reset during LOAD or a wait discards the partial frame and the in-flight sample. The filter must be reset together with this block.
- **Latency:** `sample_stb` at cycle T with no pending frame gives `flt_start` at T+1. With a pending frame, `flt_coef_load` is high T+1..T+NCOEF and `flt_start` is at T+NCOEF+1.
- **Output:** `pcm_valid` is asserted 1 cycle after `flt_done` rises for the last section.
- **Overrun:** `sample_stb` in any state other than IDLE pulses `overrun` in the next cycle, and the sample is dropped.
- **Simultaneous events:**
  - A beat completing the frame in the same cycle as `sample_stb` in IDLE does not take effect for that sample, because `pending` is sampled before its update. The frame loads at the next strobe.
  - `frm_valid` while `pending` is set stalls the decoder: `frm_ready` stays 0 until LOAD completes.

## Structure
- `speech256_pkg`: COEF_W, SIG_W, NCOEF, SECTIONS constants and the `seq_state_t` enum.
- Sub-module `coef_frame_buf`: buffer, `wi`, `pending`, and the read port indexed by `lc`. The FSM stays in `filter_sequencer`.

## Test plan
- **Reset:** hold `rst` 3 cycles with `frm_valid = 1` → all outputs 0, `frm_ready = 0` during reset, 1 after.
- **Frame load:** send coefficients 0x001..0x00C, then `sample_stb` → 12 consecutive `flt_coef_load` cycles carrying 0x001..0x00C in order, `frm_ready` low throughout.
- **Sections:** behavioural filter model with 8-cycle sections returning `src_in + 1`; `src_in = 0x1234` → exactly 6 `flt_start` pulses, `pcm_out = 0x1235`, a single `pcm_valid`.
- **Overrun:** second `sample_stb` 5 cycles after the first → `overrun` pulse, the first sample still completes, the second produces no `pcm_valid`.
- **Back-pressure:** a second frame (0x100..0x10B) streamed while the first is pending → `frm_ready = 0` until LOAD ends, then accepted. The next strobe loads 0x100..0x10B.
- **Mid-operation reset:** assert `rst` in WAIT_HI → next cycle IDLE, `pending = 0`, no `pcm_valid`.
